// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: frames UART RX bytes into register-file write/read
// commands and returns read data to UART TX over a valid/busy handshake.
// Ports: CLK/RST (async active-low); RX_P_DATA/RX_D_VLD from UART_RX;
//   RF_ADDR/RF_WR_EN/RF_WR_DATA/RF_RD_EN/RF_RD_DATA/RF_RD_VLD to the
//   register file; TX_P_DATA/TX_D_VLD/TX_BUSY to UART_TX; CMD_ERR pulse.
// Option: define UART_CMD_TIMEOUT_EN to abandon a frame after
//   TIMEOUT_CYCLES idle cycles between its bytes.
module uart_cmd_ctrl #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] RX_P_DATA,
   input  logic                  RX_D_VLD,
   output logic [ADDR_WIDTH-1:0] RF_ADDR,
   output logic                  RF_WR_EN,
   output logic [DATA_WIDTH-1:0] RF_WR_DATA,
   output logic                  RF_RD_EN,
   input  logic [DATA_WIDTH-1:0] RF_RD_DATA,
   input  logic                  RF_RD_VLD,
   output logic [DATA_WIDTH-1:0] TX_P_DATA,
   output logic                  TX_D_VLD,
   input  logic                  TX_BUSY,
   output logic                  CMD_ERR
);

   localparam logic [DATA_WIDTH-1:0] CMD_WR = DATA_WIDTH'(8'hAA);
   localparam logic [DATA_WIDTH-1:0] CMD_RD = DATA_WIDTH'(8'hBB);

   typedef enum logic [2:0] {
      IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
   logic                    wr_en_q, wr_en_d;
   logic                    rd_en_q, rd_en_d;
   logic                    tx_vld_q, tx_vld_d;
   logic                    err_q, err_d;
   logic                    timeout;

`ifdef UART_CMD_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          collecting;

   // Only the byte-collection states are guarded; the counter rests
   // at zero everywhere else so each frame starts with a full budget.
   assign collecting = state_q inside {WR_ADDR, WR_DATA, RD_ADDR};
   assign timeout    = collecting && !RX_D_VLD && (cnt_q == TO_LAST);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (RX_D_VLD || !collecting) cnt_d = '0;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES == 0);
   assign timeout        = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      tx_data_d = tx_data_q;
      wr_en_d   = 1'b0;
      rd_en_d   = 1'b0;
      tx_vld_d  = 1'b0;
      err_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (RX_D_VLD) begin
               if (RX_P_DATA == CMD_WR)      state_d = WR_ADDR;
               else if (RX_P_DATA == CMD_RD) state_d = RD_ADDR;
               else                          err_d   = 1'b1;
            end
         end
         WR_ADDR: begin
            if (RX_D_VLD) begin
               addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
               state_d = WR_DATA;
            end else if (timeout) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end
         end
         WR_DATA: begin
            if (RX_D_VLD) begin
               wdata_d = RX_P_DATA;
               wr_en_d = 1'b1;
               state_d = IDLE;
            end else if (timeout) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end
         end
         RD_ADDR: begin
            if (RX_D_VLD) begin
               addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
               rd_en_d = 1'b1;
               state_d = RD_WAIT;
            end else if (timeout) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end
         end
         RD_WAIT: begin
            if (RF_RD_VLD) begin
               rdata_d = RF_RD_DATA;
               state_d = TX_SEND;
            end
            if (RX_D_VLD) err_d = 1'b1;
         end
         TX_SEND: begin
            // A byte arriving as the transmitter frees up is still
            // dropped; the pending response takes priority.
            if (!TX_BUSY) begin
               tx_vld_d  = 1'b1;
               tx_data_d = rdata_q;
               state_d   = IDLE;
            end
            if (RX_D_VLD) err_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         tx_data_q <= '0;
         wr_en_q   <= 1'b0;
         rd_en_q   <= 1'b0;
         tx_vld_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         tx_data_q <= tx_data_d;
         wr_en_q   <= wr_en_d;
         rd_en_q   <= rd_en_d;
         tx_vld_q  <= tx_vld_d;
         err_q     <= err_d;
      end
   end

   assign RF_ADDR    = addr_q;
   assign RF_WR_EN   = wr_en_q;
   assign RF_WR_DATA = wdata_q;
   assign RF_RD_EN   = rd_en_q;
   assign TX_P_DATA  = tx_data_q;
   assign TX_D_VLD   = tx_vld_q;
   assign CMD_ERR    = err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed + randomized frames for uart_cmd_ctrl,
// checked against a byte-level command model and an emulated register file.
module tb_uart_cmd_ctrl;

   logic       CLK = 1'b0;
   logic       RST;
   logic [7:0] RX_P_DATA;
   logic       RX_D_VLD;
   logic [3:0] RF_ADDR;
   logic       RF_WR_EN;
   logic [7:0] RF_WR_DATA;
   logic       RF_RD_EN;
   logic [7:0] RF_RD_DATA;
   logic       RF_RD_VLD;
   logic [7:0] TX_P_DATA;
   logic       TX_D_VLD;
   logic       TX_BUSY;
   logic       CMD_ERR;

   uart_cmd_ctrl #(
      .DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(16)
   ) dut (
      .CLK(CLK), .RST(RST),
      .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
      .RF_ADDR(RF_ADDR), .RF_WR_EN(RF_WR_EN), .RF_WR_DATA(RF_WR_DATA),
      .RF_RD_EN(RF_RD_EN), .RF_RD_DATA(RF_RD_DATA), .RF_RD_VLD(RF_RD_VLD),
      .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY),
      .CMD_ERR(CMD_ERR)
   );

   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;
   int n_wr = 0, n_rd = 0, n_tx = 0, n_err = 0, n_both = 0;
   int exp_wr = 0, exp_rd = 0, exp_tx = 0, exp_err = 0;

   logic [7:0] model  [16];
   logic [7:0] rf_mem [16];

   // Register-file emulation and pulse accounting, mid-cycle.
   always @(negedge CLK) begin
      if (RST) begin
         if (RF_WR_EN) begin
            n_wr++;
            rf_mem[RF_ADDR] = RF_WR_DATA;
         end
         if (RF_RD_EN) n_rd++;
         if (TX_D_VLD) n_tx++;
         if (CMD_ERR)  n_err++;
         if (RF_WR_EN && RF_RD_EN) n_both++;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      RX_P_DATA = b;
      RX_D_VLD  = 1'b1;
      tick();
      RX_D_VLD  = 1'b0;
      RX_P_DATA = 8'($urandom);
   endtask

   function automatic logic [31:0] outs();
      return 32'({RF_ADDR, RF_WR_EN, RF_WR_DATA, RF_RD_EN,
                  TX_P_DATA, TX_D_VLD, CMD_ERR});
   endfunction

   task automatic do_write(input logic [7:0] a, input logic [7:0] d);
      send_byte(8'hAA);
      send_byte(a);
      send_byte(d);
      chk("wr_en", 32'(RF_WR_EN), 1);
      chk("wr_addr", 32'(RF_ADDR), 32'(a[3:0]));
      chk("wr_data", 32'(RF_WR_DATA), 32'(d));
      chk("wr_err", 32'(CMD_ERR), 0);
      model[a[3:0]] = d;
      exp_wr++;
   endtask

   task automatic do_read(input logic [7:0] a, input int lat,
                          input int busy, input bit drop);
      logic [3:0] ra;
      logic [7:0] exp_d;
      int         k;
      int         early;
      ra    = a[3:0];
      exp_d = model[ra];
      TX_BUSY = (busy > 0);
      send_byte(8'hBB);
      send_byte(a);
      chk("rd_en", 32'(RF_RD_EN), 1);
      chk("rd_addr", 32'(RF_ADDR), 32'(ra));
      exp_rd++;
      tick();
      chk("rd_en_low", 32'(RF_RD_EN), 0);
      if (drop) begin
         send_byte(8'h55);
         chk("drop_err", 32'(CMD_ERR), 1);
         exp_err++;
      end
      repeat (lat - 1) tick();
      RF_RD_DATA = rf_mem[ra];
      RF_RD_VLD  = 1'b1;
      tick();
      RF_RD_VLD  = 1'b0;
      RF_RD_DATA = 8'($urandom);
      if (busy == 0) begin
         k = 0;
         while (k < 4 && !TX_D_VLD) begin
            tick();
            k++;
         end
         chk("tx_lat", 32'(k <= 1), 1);
      end else begin
         early = 0;
         for (int i = 0; i < busy; i++) begin
            if (TX_D_VLD) early++;
            tick();
         end
         chk("tx_while_busy", 32'(early), 0);
         TX_BUSY = 1'b0;
         tick();
         chk("tx_after_busy", 32'(TX_D_VLD), 1);
      end
      chk("tx_data", 32'(TX_P_DATA), 32'(exp_d));
      exp_tx++;
      tick();
      chk("tx_low", 32'(TX_D_VLD), 0);
      chk("tx_hold", 32'(TX_P_DATA), 32'(exp_d));
   endtask

   initial begin
      int         kind;
      logic [7:0] b;
      int         errs;
      for (int i = 0; i < 16; i++) begin
         model[i]  = 8'h00;
         rf_mem[i] = 8'h00;
      end
      RST = 1'b0;
      RX_P_DATA = 8'h00;
      RX_D_VLD = 1'b0;
      RF_RD_DATA = 8'h00;
      RF_RD_VLD = 1'b0;
      TX_BUSY = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      chk("reset_outs", outs(), 0);
      RST = 1'b1;
      tick();

      do_write(8'h05, 8'h3C);
      tick();
      chk("wr_pulse_once", 32'(RF_WR_EN), 0);
      do_write(8'h03, 8'h7E);
      do_read(8'h13, 2, 0, 1'b0);
      do_read(8'h13, 2, 40, 1'b0);

      send_byte(8'h55);
      chk("unknown_err", 32'(CMD_ERR), 1);
      exp_err++;
      tick();
      chk("unknown_err_low", 32'(CMD_ERR), 0);
      do_read(8'h05, 3, 0, 1'b1);

      RF_RD_DATA = 8'hA5;
      RF_RD_VLD  = 1'b1;
      tick();
      RF_RD_VLD  = 1'b0;
      repeat (3) tick();

      send_byte(8'hAA);
      send_byte(8'h02);
      RST = 1'b0;
      #1;
      chk("rst_async_outs", outs(), 0);
      tick();
      tick();
      chk("rst_hold_outs", outs(), 0);
      RST = 1'b1;
      tick();
      send_byte(8'h3C);
      chk("post_rst_err", 32'(CMD_ERR), 1);
      chk("post_rst_no_wr", 32'(RF_WR_EN), 0);
      exp_err++;
      tick();

`ifdef UART_CMD_TIMEOUT_EN
      send_byte(8'hAA);
      send_byte(8'h02);
      errs = 0;
      for (int i = 1; i < 16; i++) begin
         if (CMD_ERR) errs++;
         tick();
      end
      chk("to_early", 32'(errs), 0);
      tick();
      chk("to_err", 32'(CMD_ERR), 1);
      exp_err++;
      repeat (4) tick();
      do_read(8'h02, 1, 0, 1'b0);
`else
      send_byte(8'hAA);
      send_byte(8'h02);
      errs = 0;
      for (int i = 0; i < 40; i++) begin
         if (CMD_ERR) errs++;
         tick();
      end
      chk("no_to_err", 32'(errs), 0);
      send_byte(8'h99);
      chk("late_wr_en", 32'(RF_WR_EN), 1);
      chk("late_wr_data", 32'(RF_WR_DATA), 32'h99);
      model[2] = 8'h99;
      exp_wr++;
`endif

      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 3);
         if (kind <= 1) begin
            do_write(8'($urandom), 8'($urandom));
         end else if (kind == 2) begin
            do_read(8'($urandom), $urandom_range(1, 4),
                    $urandom_range(0, 5), 1'($urandom_range(0, 1)));
         end else begin
            b = 8'($urandom);
            if (b == 8'hAA || b == 8'hBB) b = 8'h11;
            send_byte(b);
            chk("rand_unknown_err", 32'(CMD_ERR), 1);
            exp_err++;
         end
      end
      repeat (3) tick();

      chk("count_wr", 32'(n_wr), 32'(exp_wr));
      chk("count_rd", 32'(n_rd), 32'(exp_rd));
      chk("count_tx", 32'(n_tx), 32'(exp_tx));
      chk("count_err", 32'(n_err), 32'(exp_err));
      chk("wr_rd_overlap", 32'(n_both), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
- Command sequencer between the UART receive path and the register file.
- Collects byte frames from the receiver's parallel output (P_DATA/DATA_VALID), decodes write and read commands, and drives single-cycle register-file strobes.
- Returns read data to the UART transmitter through a valid/busy handshake.
- Sits in the system top between UART_RX, the register file and UART_TX.

Parameters:
- DATA_WIDTH, 8, byte width of RX, TX and register-file data.
- ADDR_WIDTH, 4, register-file address width; the low ADDR_WIDTH bits of the address byte are used and the upper bits are ignored.
- TIMEOUT_CYCLES, 1024, idle CLK cycles allowed between bytes of one frame (used only with the optional feature).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous active-low reset.
- RX_P_DATA  in  DATA_WIDTH  received byte, connected to UART_RX P_DATA.
- RX_D_VLD  in  1  one-cycle pulse per received byte, connected to UART_RX DATA_VALID.
- RF_ADDR  out  ADDR_WIDTH  register-file address.
- RF_WR_EN  out  1  one-cycle write strobe.
- RF_WR_DATA  out  DATA_WIDTH  write data.
- RF_RD_EN  out  1  one-cycle read strobe.
- RF_RD_DATA  in  DATA_WIDTH  read data from the register file.
- RF_RD_VLD  in  1  read data valid, arrives one or more cycles after RF_RD_EN.
- TX_P_DATA  out  DATA_WIDTH  byte to transmit.
- TX_D_VLD  out  1  one-cycle transmit request.
- TX_BUSY  in  1  transmitter busy; no request may be issued while it is high.
- CMD_ERR  out  1  one-cycle error pulse.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal address and data registers 0. Reset is asynchronous and may assert in any state; an in-progress frame is discarded with no strobe issued.
- All outputs are registered. Strobes appear on the cycle after the triggering input is sampled.
- Frame formats:
  - Write: 0xAA, ADDR, DATA.
  - Read: 0xBB, ADDR.
- States and transitions:
  - IDLE: on RX_D_VLD, 0xAA goes to WR_ADDR and 0xBB goes to RD_ADDR. Any other byte pulses CMD_ERR for one cycle and the block stays in IDLE.
  - WR_ADDR: on RX_D_VLD, latch RX_P_DATA[ADDR_WIDTH-1:0] and go to WR_DATA.
  - WR_DATA: on RX_D_VLD, on the next cycle drive RF_WR_EN=1 with RF_ADDR and RF_WR_DATA=byte, then go to IDLE.
  - RD_ADDR: on RX_D_VLD, latch the address, drive RF_RD_EN=1 for one cycle, then go to RD_WAIT.
  - RD_WAIT: on RF_RD_VLD, capture RF_RD_DATA and go to TX_SEND.
  - TX_SEND: on the first edge where TX_BUSY=0, drive TX_D_VLD=1 for one cycle with TX_P_DATA=captured data, then go to IDLE. TX_P_DATA holds its value until the next request.
- RX_D_VLD in RD_WAIT or TX_SEND: the byte is dropped, CMD_ERR pulses, and the state is unchanged.
- RF_RD_VLD outside RD_WAIT is ignored.
- RF_RD_EN and RF_WR_EN are never high in the same cycle, and each is high for at most one cycle per frame.
- RF_ADDR holds the last latched address between accesses.
- RX_D_VLD and the TX_BUSY fall in the same cycle in TX_SEND: the TX request wins and the byte is dropped with CMD_ERR.
- Back-to-back frames: the 0xAA/0xBB of the next frame is accepted in the cycle immediately after returning to IDLE.

Optional Feature:
- Macro: UART_CMD_TIMEOUT_EN.
- When defined: a counter clears on every RX_D_VLD. In WR_ADDR, WR_DATA or RD_ADDR, if TIMEOUT_CYCLES cycles elapse with no byte, the block returns to IDLE and pulses CMD_ERR for one cycle; no register-file strobe is issued. RD_WAIT and TX_SEND never time out.
- When undefined: there is no counter, and the frame-collection states wait indefinitely.

Test Plan:
- Write: bytes 0xAA, 0x05, 0x3C -> one RF_WR_EN pulse with RF_ADDR=5 and RF_WR_DATA=0x3C, one cycle after the third RX_D_VLD; CMD_ERR stays 0.
- Read: bytes 0xBB, 0x13; the register file returns 0x7E two cycles after RF_RD_EN, with TX_BUSY=0 -> RF_RD_EN pulses with RF_ADDR=3, then TX_D_VLD pulses with TX_P_DATA=0x7E one cycle after RF_RD_VLD.
- Busy transmitter: same read with TX_BUSY held high for 40 cycles -> no TX_D_VLD while busy; exactly one TX_D_VLD on the cycle after TX_BUSY falls; data 0x7E.
- Unknown command and dropped byte: 0x55 in IDLE, then a byte in RD_WAIT -> CMD_ERR pulses once for each; state unaffected; no strobes.
- Reset mid-frame: 0xAA, 0x02, then RST low for 2 cycles, then 0x3C -> no RF_WR_EN pulse; 0x3C raises CMD_ERR in IDLE; all outputs 0 during reset.
- Timeout (UART_CMD_TIMEOUT_EN, TIMEOUT_CYCLES=16): 0xAA, 0x02, then 20 idle cycles -> CMD_ERR at cycle 16 and return to IDLE; a following 0xBB, 0x02 completes a normal read.
